// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared types for the MEM/WB write-back stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_src_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_load_align.sv
// ============================================================================
// Module   : wb_load_align
// Brief    : Combinational load lane extraction and sign/zero extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  raw_i,
    input  logic [OFF_W-1:0] off_i,
    input  mem_size_e        size_i,
    input  logic             unsigned_i,
    output logic [XLEN-1:0]  data_o
);

    // Work at 64 bits throughout; for XLEN=32 the upper half is discarded,
    // which also makes size D collapse onto the word result.
    logic [63:0] w_raw;
    logic [2:0]  w_off;
    logic [2:0]  w_off_al;
    logic [63:0] w_lane;
    logic [63:0] w_ext;

    assign w_raw = 64'(raw_i);
    assign w_off = 3'(off_i);

    always_comb begin
        w_off_al = w_off;
        w_lane   = '0;
        w_ext    = w_raw;
        unique case (size_i)
            SZ_B:       w_off_al = w_off;
            SZ_H:       w_off_al = {w_off[2:1], 1'b0};
            SZ_W, SZ_D: w_off_al = {w_off[2], 2'b00};
        endcase
        w_lane = w_raw >> {w_off_al, 3'b000};
        unique case (size_i)
            SZ_B: w_ext = {{56{~unsigned_i & w_lane[7]}},  w_lane[7:0]};
            SZ_H: w_ext = {{48{~unsigned_i & w_lane[15]}}, w_lane[15:0]};
            SZ_W: w_ext = {{32{~unsigned_i & w_lane[31]}}, w_lane[31:0]};
            SZ_D: w_ext = w_raw;
        endcase
    end

    assign data_o = w_ext[XLEN-1:0];

endmodule : wb_load_align

`default_nettype wire

// File: rtl/wb_stage_pipe.sv
// ============================================================================
// Module   : wb_stage_pipe
// Brief    : Registered MEM/WB stage: valid/ready capture, 4-way write-back
//            source select, load extension, register-file write port.
// Options  : WB_RETIRE_CNT_EN - enables the 64-bit retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 regwrite_i,
    input  wb_src_e              wb_src_i,
    input  mem_size_e            mem_size_i,
    input  logic                 mem_unsigned_i,
    input  logic [REGADDR_W-1:0] rd_i,
    input  logic [XLEN-1:0]      alu_result_i,
    input  logic [XLEN-1:0]      read_data_i,
    input  logic [XLEN-1:0]      pc_plus4_i,
    input  logic [XLEN-1:0]      imm_i,
    output logic                 rf_we_o,
    output logic [REGADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    output logic                 fwd_valid_o,
    output logic [63:0]          retire_cnt_o
);

    localparam int OFF_W = $clog2(XLEN / 8);

    logic                 r_valid;
    logic                 r_regwrite;
    logic                 r_mem_unsigned;
    wb_src_e              r_wb_src;
    mem_size_e            r_mem_size;
    logic [REGADDR_W-1:0] r_rd;
    logic [XLEN-1:0]      r_alu;
    logic [XLEN-1:0]      r_read_data;
    logic [XLEN-1:0]      r_pc4;
    logic [XLEN-1:0]      r_imm;

    logic [XLEN-1:0]      w_load_data;
    logic [XLEN-1:0]      w_wdata;

    // Stall outranks flush so an entry already held is never cancelled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_regwrite     <= 1'b0;
            r_mem_unsigned <= 1'b0;
            r_wb_src       <= WB_ALU;
            r_mem_size     <= SZ_B;
            r_rd           <= '0;
            r_alu          <= '0;
            r_read_data    <= '0;
            r_pc4          <= '0;
            r_imm          <= '0;
        end else if (stall_i) begin
            r_valid <= r_valid;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_valid        <= 1'b1;
            r_regwrite     <= regwrite_i;
            r_mem_unsigned <= mem_unsigned_i;
            r_wb_src       <= wb_src_i;
            r_mem_size     <= mem_size_i;
            r_rd           <= rd_i;
            r_alu          <= alu_result_i;
            r_read_data    <= read_data_i;
            r_pc4          <= pc_plus4_i;
            r_imm          <= imm_i;
        end else begin
            r_valid <= 1'b0;
        end
    end

    wb_load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .raw_i      (r_read_data),
        .off_i      (r_alu[OFF_W-1:0]),
        .size_i     (r_mem_size),
        .unsigned_i (r_mem_unsigned),
        .data_o     (w_load_data)
    );

    always_comb begin
        w_wdata = r_alu;
        unique case (r_wb_src)
            WB_ALU: w_wdata = r_alu;
            WB_MEM: w_wdata = w_load_data;
            WB_PC4: w_wdata = r_pc4;
            WB_IMM: w_wdata = r_imm;
        endcase
    end

    // Gating with the live stall makes a held entry write once, on release.
    assign rf_we_o     = r_valid & r_regwrite & (r_rd != '0) & ~stall_i;
    assign rf_waddr_o  = r_rd;
    assign rf_wdata_o  = w_wdata;
    assign fwd_valid_o = rf_we_o;
    assign in_ready    = ~stall_i;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !stall_i) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign retire_cnt_o = r_retire_cnt;
`else
    assign retire_cnt_o = '0;
`endif

endmodule : wb_stage_pipe

`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
// ============================================================================
// Module   : tb_wb_stage_pipe
// Brief    : Scoreboard bench for wb_stage_pipe with directed load/stall/flush vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage_pipe;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        stall_i;
    logic        flush_i;
    logic        regwrite_i;
    wb_src_e     wb_src_i;
    mem_size_e   mem_size_i;
    logic        mem_unsigned_i;
    logic [4:0]  rd_i;
    logic [63:0] alu_result_i;
    logic [63:0] read_data_i;
    logic [63:0] pc_plus4_i;
    logic [63:0] imm_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [63:0] rf_wdata_o;
    logic        fwd_valid_o;
    logic [63:0] retire_cnt_o;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks    = 0;
    int  n_pass      = 0;
    int  exp_retire  = 0;
    bit  drop_next   = 1'b0;

    always #5 clk = ~clk;

    wb_stage_pipe #(
        .XLEN      (64),
        .REGADDR_W (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .regwrite_i     (regwrite_i),
        .wb_src_i       (wb_src_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .rd_i           (rd_i),
        .alu_result_i   (alu_result_i),
        .read_data_i    (read_data_i),
        .pc_plus4_i     (pc_plus4_i),
        .imm_i          (imm_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .fwd_valid_o    (fwd_valid_o),
        .retire_cnt_o   (retire_cnt_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && rf_we_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_write: got write to x%0d data 0x%0h, expected none",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wb_waddr", 64'(rf_waddr_o), 64'(e.addr));
                check("wb_wdata", rf_wdata_o, e.data);
                check("wb_fwd_valid", 64'(fwd_valid_o), 64'd1);
            end
        end
    end

    task automatic send(input logic [4:0] rd, input wb_src_e src, input mem_size_e sz,
                        input logic uns, input logic rw, input logic [63:0] alu,
                        input logic [63:0] exp_data);
        in_valid       = 1'b1;
        rd_i           = rd;
        wb_src_i       = src;
        mem_size_i     = sz;
        mem_unsigned_i = uns;
        regwrite_i     = rw;
        alu_result_i   = alu;
        if (!stall_i && !flush_i) begin
            exp_retire++;
            if (rw && rd != 5'd0 && !drop_next) exp_q.push_back('{rd, exp_data});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'($urandom);
        stall_i        = 1'($urandom);
        flush_i        = 1'($urandom);
        regwrite_i     = 1'b1;
        wb_src_i       = wb_src_e'(2'($urandom));
        mem_size_i     = mem_size_e'(2'($urandom));
        mem_unsigned_i = 1'($urandom);
        rd_i           = 5'($urandom);
        alu_result_i   = {$urandom, $urandom};
        read_data_i    = {$urandom, $urandom};
        pc_plus4_i     = {$urandom, $urandom};
        imm_i          = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        check("reset_rf_we", 64'(rf_we_o), 64'd0);
        check("reset_waddr", 64'(rf_waddr_o), 64'd0);
        check("reset_wdata", rf_wdata_o, 64'd0);
        check("reset_fwd_valid", 64'(fwd_valid_o), 64'd0);
        check("reset_retire_cnt", retire_cnt_o, 64'd0);

        @(posedge clk); #1;
        in_valid     = 1'b0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        regwrite_i   = 1'b0;
        read_data_i  = 64'h80FF_7F01_8000_00F0;
        pc_plus4_i   = 64'h0000_0000_1000_0004;
        imm_i        = 64'hFFFF_FFFF_ABCD_E000;
        rst_n        = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_rf_we", 64'(rf_we_o), 64'd0);
        end
        check("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        send(5'd5,  WB_ALU, SZ_D, 1'b0, 1'b1, 64'h1234, 64'h1234);
        send(5'd0,  WB_ALU, SZ_D, 1'b0, 1'b1, 64'h1234, 64'h1234);
        send(5'd7,  WB_MEM, SZ_B, 1'b0, 1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0);
        send(5'd8,  WB_MEM, SZ_B, 1'b1, 1'b1, 64'h2000, 64'h0000_0000_0000_00F0);
        send(5'd9,  WB_MEM, SZ_H, 1'b0, 1'b1, 64'h2004, 64'h0000_0000_0000_7F01);
        send(5'd10, WB_MEM, SZ_W, 1'b0, 1'b1, 64'h2004, 64'hFFFF_FFFF_80FF_7F01);
        send(5'd11, WB_MEM, SZ_H, 1'b0, 1'b1, 64'h2003, 64'hFFFF_FFFF_FFFF_8000);
        send(5'd12, WB_MEM, SZ_H, 1'b1, 1'b1, 64'h2003, 64'h0000_0000_0000_8000);
        send(5'd13, WB_MEM, SZ_B, 1'b0, 1'b1, 64'h2007, 64'hFFFF_FFFF_FFFF_FF80);
        send(5'd14, WB_MEM, SZ_W, 1'b1, 1'b1, 64'h2002, 64'h0000_0000_8000_00F0);
        send(5'd15, WB_MEM, SZ_D, 1'b0, 1'b1, 64'h2005, 64'h80FF_7F01_8000_00F0);
        send(5'd16, WB_PC4, SZ_D, 1'b0, 1'b1, 64'h1234, 64'h0000_0000_1000_0004);
        send(5'd17, WB_IMM, SZ_D, 1'b0, 1'b1, 64'h1234, 64'hFFFF_FFFF_ABCD_E000);
        send(5'd18, WB_ALU, SZ_D, 1'b0, 1'b0, 64'h1818, 64'h1818);

        // Held entry must write exactly once, after stall drops.
        send(5'd3, WB_ALU, SZ_D, 1'b0, 1'b1, 64'hAA55, 64'hAA55);
        stall_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        @(posedge clk); #1;

        flush_i = 1'b1;
        send(5'd6, WB_ALU, SZ_D, 1'b0, 1'b1, 64'h6666, 64'h6666);
        @(posedge clk); #1;

        // Flush coinciding with stall release kills only the incoming instruction.
        send(5'd19, WB_ALU, SZ_D, 1'b0, 1'b1, 64'h1919, 64'h1919);
        stall_i = 1'b1;
        @(posedge clk); #1;
        stall_i = 1'b0;
        flush_i = 1'b1;
        send(5'd20, WB_ALU, SZ_D, 1'b0, 1'b1, 64'h2020, 64'h2020);
        repeat (2) begin
            @(posedge clk); #1;
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_pending_writes", 64'(exp_q.size()), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("retire_cnt", retire_cnt_o, 64'(exp_retire));
`else
        check("retire_cnt_tied", retire_cnt_o, 64'd0);
`endif

        // Asynchronous reset while an entry is held: it must vanish without a write.
        drop_next = 1'b1;
        send(5'd21, WB_ALU, SZ_D, 1'b0, 1'b1, 64'h2121, 64'h2121);
        drop_next = 1'b0;
        stall_i = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(negedge clk);
        check("midstall_reset_rf_we", 64'(rf_we_o), 64'd0);
        check("midstall_reset_wdata", rf_wdata_o, 64'd0);
        check("midstall_reset_retire", retire_cnt_o, 64'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        stall_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("post_reset_waddr", 64'(rf_waddr_o), 64'd0);
        check("post_reset_pending", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_wb_stage_pipe

`default_nettype wire
